// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending CPU stores draining to data memory.
// Ports: clk/rst_n; st_* store request (st_ready, st_misaligned out);
//   ld_valid/ld_addr load probe (ld_stall out); mem_sb/sh/sw, mem_addr,
//   mem_wdata write port; empty, count status.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    input  logic [1:0]              st_size,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    output logic                    st_ready,
    output logic                    st_misaligned,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_addr,
    output logic                    ld_stall,
    output logic                    mem_sb,
    output logic                    mem_sh,
    output logic                    mem_sw,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entry storage is never read unless its pend bit is set, so no reset.
    logic [31:0] ent_addr_q [DEPTH];
    logic [31:0] ent_data_q [DEPTH];
    logic [1:0]  ent_size_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] pend_q, pend_d;
    logic             push;
    logic             drain;
    logic             hit;
    logic             unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr[1:0];

    always_comb begin
        st_misaligned = 1'b0;
        if (st_valid) begin
            unique case (st_size)
                2'b00:   st_misaligned = 1'b0;
                2'b01:   st_misaligned = st_addr[0];
                2'b10:   st_misaligned = |st_addr[1:0];
                default: st_misaligned = 1'b1;
            endcase
        end
    end

    // Word-granular match against every pending entry.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pend_q[i] && (ent_addr_q[i][31:2] == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall = ld_valid && hit;
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = (count_q != FULL);
    assign push     = st_valid && st_ready && !st_misaligned;
    // A stalled load gives up the port so its conflicting store can retire.
    assign drain    = !empty && (!ld_valid || ld_stall);

    always_comb begin
        mem_sb    = 1'b0;
        mem_sh    = 1'b0;
        mem_sw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = ent_addr_q[rd_ptr_q];
            mem_wdata = ent_data_q[rd_ptr_q];
            unique case (ent_size_q[rd_ptr_q])
                2'b00:   mem_sb = 1'b1;
                2'b01:   mem_sh = 1'b1;
                default: mem_sw = 1'b1;
            endcase
        end
    end

    // Push and pop never touch the same slot: push needs !full, pop needs !empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = pend_q;
        if (drain) begin
            pend_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        if (push) begin
            pend_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(drain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= st_addr;
            ent_data_q[wr_ptr_q] <= st_data;
            ent_size_q[wr_ptr_q] <= st_size;
        end
    end

endmodule
